// File: rtl/carfield_cfg_pkg.sv
// Shared configuration for the Carfield clock-divider controller:
// domain count, division width, default-division array type and channel states.
package carfield_cfg_pkg;

  localparam int NumDomains = 6;
  localparam int DivWidth   = 8;

  typedef logic [NumDomains-1:0][DivWidth-1:0] div_array_t;

  localparam div_array_t DefaultDivAll = {NumDomains{DivWidth'(1)}};

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPend = 2'd1,
    StOff  = 2'd2
  } div_state_e;

endpackage

// File: rtl/carfield_clk_div_ctrl_if.sv
// Per-domain reconfiguration and status bundle shared by the controller and its channels.
interface carfield_clk_div_ctrl_if #(
  parameter int NumDomains = carfield_cfg_pkg::NumDomains,
  parameter int DivWidth   = carfield_cfg_pkg::DivWidth
) ();

  logic [NumDomains-1:0]               cfg_valid;
  logic [NumDomains-1:0]               cfg_ready;
  logic [NumDomains-1:0][DivWidth-1:0] cfg_div;
  logic [NumDomains-1:0]               cfg_en;
  logic [NumDomains-1:0]               tick;
  logic [NumDomains-1:0]               busy;
  logic [NumDomains-1:0][DivWidth-1:0] cur_div;

  modport master (
    output cfg_valid, cfg_div, cfg_en,
    input  cfg_ready, tick, busy, cur_div
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_en,
    output cfg_ready, tick, busy, cur_div
  );

endinterface

// File: rtl/carfield_clk_div_chan.sv
// One divided-clock domain: tick counter, shadowed reconfiguration and the
// RUN/PEND/OFF sequencer that applies changes only on a period boundary.
//
// state  | meaning
// StRun  | ticking at cur_div, new request accepted into the shadow
// StPend | ticking on the old schedule, shadow applied at the next tick
// StOff  | no ticks, cnt held at 0, request applied on the next cycle
module carfield_clk_div_chan
  import carfield_cfg_pkg::*;
#(
  parameter int                  DivWidth   = carfield_cfg_pkg::DivWidth,
  parameter int                  Idx        = 0,
  parameter logic [DivWidth-1:0] DefaultDiv = DivWidth'(1),
  parameter logic                DefaultEn  = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  carfield_clk_div_ctrl_if.slave   bus
);

  localparam logic [DivWidth-1:0] One      = DivWidth'(1);
  localparam logic [DivWidth-1:0] ResetDiv = (DefaultDiv == '0) ? One : DefaultDiv;

  div_state_e          state_q, state_d;
  logic [DivWidth-1:0] cnt_q, cnt_d;
  logic [DivWidth-1:0] cur_div_q, cur_div_d;
  logic [DivWidth-1:0] sh_div_q, sh_div_d;
  logic                sh_en_q, sh_en_d;
  logic [DivWidth-1:0] req_div;
  logic                tick;
  logic                accept;

  assign req_div = (bus.cfg_div[Idx] == '0) ? One : bus.cfg_div[Idx];
  assign tick    = (state_q != StOff) && (cnt_q == cur_div_q - One);
  assign accept  = bus.cfg_valid[Idx] && (state_q != StPend);

  assign bus.tick[Idx]      = tick;
  assign bus.cfg_ready[Idx] = (state_q != StPend);
  assign bus.busy[Idx]      = (state_q == StPend);
  assign bus.cur_div[Idx]   = cur_div_q;

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    sh_div_d  = sh_div_q;
    sh_en_d   = sh_en_q;
    cnt_d     = tick ? '0 : cnt_q + One;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          sh_div_d = req_div;
          sh_en_d  = bus.cfg_en[Idx];
          state_d  = StPend;
        end
      end
      StPend: begin
        if (tick) begin
          cur_div_d = sh_div_q;
          state_d   = sh_en_q ? StRun : StOff;
        end
      end
      default: begin
        cnt_d = '0;
        if (accept) begin
          cur_div_d = req_div;
          state_d   = bus.cfg_en[Idx] ? StRun : StOff;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= DefaultEn ? StRun : StOff;
      cnt_q     <= '0;
      cur_div_q <= ResetDiv;
      sh_div_q  <= '0;
      sh_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      sh_div_q  <= sh_div_d;
      sh_en_q   <= sh_en_d;
    end
  end

endmodule

// File: rtl/carfield_clk_div_ctrl.sv
// Multi-domain clock-enable divider with glitch-free per-domain reconfiguration.
// Flat ports are gathered into the shared bundle; each domain is an independent channel.
module carfield_clk_div_ctrl
  import carfield_cfg_pkg::*;
#(
  parameter int                    NumDomains = carfield_cfg_pkg::NumDomains,
  parameter int                    DivWidth   = carfield_cfg_pkg::DivWidth,
  parameter div_array_t            DefaultDiv = DefaultDivAll,
  parameter logic [NumDomains-1:0] DefaultEn  = {NumDomains{1'b1}}
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumDomains-1:0]          cfg_valid_i,
  output logic [NumDomains-1:0]          cfg_ready_o,
  input  logic [NumDomains*DivWidth-1:0] cfg_div_i,
  input  logic [NumDomains-1:0]          cfg_en_i,
  output logic [NumDomains-1:0]          tick_o,
  output logic [NumDomains-1:0]          busy_o,
  output logic [NumDomains*DivWidth-1:0] cur_div_o
);

  carfield_clk_div_ctrl_if #(
    .NumDomains (NumDomains),
    .DivWidth   (DivWidth)
  ) chan_bus ();

  assign chan_bus.cfg_valid = cfg_valid_i;
  assign chan_bus.cfg_div   = cfg_div_i;
  assign chan_bus.cfg_en    = cfg_en_i;
  assign cfg_ready_o        = chan_bus.cfg_ready;
  assign tick_o             = chan_bus.tick;
  assign busy_o             = chan_bus.busy;
  assign cur_div_o          = chan_bus.cur_div;

  for (genvar g = 0; g < NumDomains; g++) begin : g_chan
    carfield_clk_div_chan #(
      .DivWidth   (DivWidth),
      .Idx        (g),
      .DefaultDiv (DefaultDiv[g]),
      .DefaultEn  (DefaultEn[g])
    ) u_chan (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (chan_bus)
    );
  end

endmodule
